// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipelined core.
//   pipe_state_t : occupancy state of a pipe_skid_reg stage.
//   ex_mem_t     : example stage payload; callers cast it to and from the
//                  opaque in_data/out_data vector of pipe_skid_reg.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,  // no entries held
    PS_ONE   = 2'd1,  // head entry only
    PS_FULL  = 2'd2   // head and skid entries
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        halt;
  } ex_mem_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: groups the handshake, payload and monitor signals of one
// pipe_skid_reg stage.
//   slave  : the stage itself (accepts in_*, produces out_*).
//   master : the environment around the stage (upstream, downstream, control).
// Handshake: a beat moves on a rising edge exactly when valid && ready are
// both high in that cycle; valid never waits on ready, and in_ready is driven
// from registers only, so it never depends combinationally on in_valid,
// out_ready or flush.
interface pipe_skid_reg_if
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_halt;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  pipe_state_t       state_dbg;

  modport slave (
    input  in_valid, in_data, in_halt, out_ready, flush,
    output in_ready, out_valid, out_data, out_halt, occupancy, stall_cnt,
           state_dbg
  );

  modport master (
    output in_valid, in_data, in_halt, out_ready, flush,
    input  in_ready, out_valid, out_data, out_halt, occupancy, stall_cnt,
           state_dbg
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that stops at all-ones instead of wrapping.
//   CLK   : clock, rising edge.
//   nRST  : asynchronous active-low reset, clears the count.
//   inc   : add one this cycle (ignored once saturated).
//   count : current value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with ready/valid handshake and a
// one-entry skid buffer. The payload is opaque, so one block serves every
// stage boundary of the core.
//   CLK  : core clock, rising edge.
//   nRST : asynchronous active-low reset, discards all entries.
//   bus  : pipe_skid_reg_if.slave
//          in_valid/in_ready/in_data/in_halt    upstream beat
//          out_valid/out_ready/out_data/out_halt head entry to downstream
//          flush      synchronous squash of all entries (wins over push/pop)
//          occupancy  entries held, 0..2 (same encoding as the state)
//          stall_cnt  saturating count of out_valid && !out_ready cycles
//          state_dbg  raw FSM state
module pipe_skid_reg
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                CNT_W     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic             CLK,
  input logic             nRST,
  pipe_skid_reg_if.slave  bus
);
  pipe_state_t       state_q,     state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              head_halt_q, head_halt_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_halt_q, skid_halt_d;
  logic              halt_seen_q, halt_seen_d;

  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              stall_inc;
  logic [CNT_W-1:0]  stall_count;

  // Ready comes purely from registers; the skid entry absorbs the beat that
  // upstream issues in the cycle before it sees in_ready fall.
  assign in_ready  = (state_q != PS_FULL) && !halt_seen_q;
  assign out_valid = (state_q != PS_EMPTY);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_halt_d = head_halt_q;
    skid_data_d = skid_data_q;
    skid_halt_d = skid_halt_q;
    halt_seen_d = halt_seen_q;

    if (bus.flush) begin
      // Any beat offered now is dropped; a pop now still counts as taken.
      state_d     = PS_EMPTY;
      head_data_d = RESET_VAL;
      head_halt_d = 1'b0;
      skid_halt_d = 1'b0;
      halt_seen_d = 1'b0;
    end else begin
      if (push && bus.in_halt) begin
        halt_seen_d = 1'b1;
      end
      case (state_q)
        PS_EMPTY: begin
          if (push) begin
            head_data_d = bus.in_data;
            head_halt_d = bus.in_halt;
            state_d     = PS_ONE;
          end
        end
        PS_ONE: begin
          if (push && !pop) begin
            skid_data_d = bus.in_data;
            skid_halt_d = bus.in_halt;
            state_d     = PS_FULL;
          end else if (push && pop) begin
            head_data_d = bus.in_data;
            head_halt_d = bus.in_halt;
          end else if (pop) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_data_d = skid_data_q;
            head_halt_d = skid_halt_q;
            state_d     = PS_ONE;
          end
        end
        default: begin
          state_d = PS_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= PS_EMPTY;
      head_data_q <= RESET_VAL;
      head_halt_q <= 1'b0;
      skid_data_q <= '0;
      skid_halt_q <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_halt_q <= head_halt_d;
      skid_data_q <= skid_data_d;
      skid_halt_q <= skid_halt_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  // A flush cycle is not a stall: the head is being discarded, not held.
  assign stall_inc = out_valid && !bus.out_ready && !bus.flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_halt  = head_halt_q && out_valid;
  assign bus.occupancy = state_q;
  assign bus.stall_cnt = stall_count;
  assign bus.state_dbg = state_q;
endmodule
